seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexes NUM_DIGITS common-anode 7-seg digits over one shared cathode bus.
//  Scans one digit at a time, with a blanking gap before each digit (anti-ghosting).
//  Uses shadow/active registers so new data appears only at a frame boundary (no tearing).
//  Sits between the key/game logic and the board anode/cathode pins; replaces the fixed-anode drive.
// PARAMETERS
//  NUM_DIGITS    8       digits scanned; idx wraps NUM_DIGITS-1 -> 0
//  DIGIT_CYCLES  100000  clk cycles per digit slot (blank + drive); 1 kHz/digit at 100 MHz
//  BLANK_CYCLES  1000    leading cycles of each slot with all anodes off; must be < DIGIT_CYCLES
// PORTS
//  clk         in   1     system clock
//  rst         in   1     asynchronous, active-high reset
//  load        in   1     1-cycle strobe; captures digit_data/digit_en/dp into shadow
//  digit_data  in   4*ND  hex nibble per digit; digit i = [4i+3:4i]
//  digit_en    in   ND    1 = digit i lit; 0 = anode held off during its slot
//  dp          in   ND    1 = decimal point of digit i lit
//  brightness  in   3     duty 1/8..8/8 (present only with SEG_PWM_EN)
//  cathode     out  8     active-low {dp,g,f,e,d,c,b,a}
//  anode       out  ND    active-low; at most one bit low at any time
//  frame_tick  out  1     1-cycle pulse on the last cycle of digit NUM_DIGITS-1
// BEHAVIOUR
//  Reset (async): anode='1, cathode=8'hFF, frame_tick=0, idx=0, state=BLANK, slot counter=0,
//   shadow/active=0 (digit_en=0), pending=0.
//  FSM: BLANK (BLANK_CYCLES cycles) -> DRIVE (DIGIT_CYCLES-BLANK_CYCLES cycles) -> BLANK, next idx.
//  BLANK: anode='1, cathode=8'hFF.
//  DRIVE: anode[idx]=~active_en[idx], others 1; cathode=decode(active nibble idx), bit7=~active_dp[idx].
//  Disabled digit: anode stays '1 through DRIVE; cathode is still driven; timing is unchanged.
//  anode, cathode and frame_tick are registered; both buses change on the same edge as the state.
//  First lit cycle after reset release: cycle BLANK_CYCLES.
//  load: shadow <= inputs, pending <= 1. Repeated loads within a frame: last one wins.
//  Frame boundary (last DRIVE cycle of idx NUM_DIGITS-1): frame_tick=1; if pending,
//   active <= shadow and pending <= 0; idx <= 0.
//  load on the boundary cycle: the pre-edge shadow is copied to active; the new value goes to shadow,
//   pending stays 1, and it applies at the next boundary.
//  Decode: 0-F standard hex (0=C0, 1=F9, 2=A4, 3=B0, ... F=8E with dp off).
//  rst asserted mid-slot: all outputs return to reset values immediately; the scan restarts at idx 0.
// CONFIGURATION
//  SEG_PWM_EN defined: the brightness port exists. Each DRIVE phase splits into 8 equal slices.
//   anode[idx] is asserted only in slices 0..brightness. Requires (DIGIT_CYCLES-BLANK_CYCLES)%8==0.
//   brightness is sampled at the start of each DRIVE phase.
//  SEG_PWM_EN undefined: no brightness port; anode is asserted for the full DRIVE phase.
// STRUCTURE
//  seg7_pkg: SEG_OFF=8'hFF; the hex->seg lookup (function); the state typedef {BLANK,DRIVE}.
//  Sub-module seg7_hex_decode: combinational nibble -> 7 active-low segments, using seg7_pkg.
//  Top level holds the counters, FSM, shadow/active registers and output registers.
// TESTING  (NUM_DIGITS=8, DIGIT_CYCLES=10, BLANK_CYCLES=2)
//  1 Reset, then release -> anode=FF, cathode=FF for 2 cycles; all anodes remain FF (digit_en=0).
//    frame_tick pulses every 80 cycles.
//  2 load 32'h76543210, en=FF, dp=00 -> after the next frame_tick: slot0 anode=FE, cathode=C0.
//    slot3 anode=F7, cathode=B0.
//  3 en=0F -> slots 4-7 keep anode=FF for all 10 cycles; slots 0-3 still drive; frame_tick period stays 80.
//  4 load mid-frame -> outputs unchanged until the boundary.
//    load on the frame_tick cycle -> applies one frame (80 cycles) later.
//  5 rst pulsed during DRIVE of slot 5 -> same cycle: anode=FF, cathode=FF.
//    After release, slot 0 starts at cycle 0.
//  6 SEG_PWM_EN, brightness=3 -> per slot: anode low exactly 4 of 8 DRIVE cycles (the first 4).
//    brightness=7 -> low all 8 DRIVE cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: blank pattern, scan states and hex lookup.
package seg7_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

   // Active-low {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-seg scanner with blanking gaps and frame-synchronous data update.
// Optional SEG_PWM_EN adds a brightness port that gates each digit's DRIVE phase in eighths.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digit_data,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   dp,
`ifdef SEG_PWM_EN
   input  logic [2:0]              brightness,
`endif
   output logic [7:0]              cathode,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_tick
);

   localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shd_data_q, shd_data_d, act_data_q, act_data_d;
   logic [NUM_DIGITS-1:0]   shd_en_q, shd_en_d, act_en_q, act_en_d;
   logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
   logic                    pending_q, pending_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [7:0]              cathode_q, cathode_d;
   logic                    frame_tick_q, frame_tick_d;
   logic                    slot_end, boundary, pwm_on;
   logic [3:0]              dec_nib;
   logic [6:0]              dec_seg;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      shd_data_d = shd_data_q;
      shd_en_d   = shd_en_q;
      shd_dp_d   = shd_dp_q;
      act_data_d = act_data_q;
      act_en_d   = act_en_q;
      act_dp_d   = act_dp_q;
      pending_d  = pending_q;

      slot_end = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
      boundary = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

      if (slot_end) begin
         cnt_d = '0;
         idx_d = boundary ? '0 : idx_q + IDX_W'(1);
      end
      state_d = (cnt_d < CNT_W'(BLANK_CYCLES)) ? BLANK : DRIVE;

      // Boundary copy happens before the load capture so a same-cycle load stays pending.
      if (boundary && pending_q) begin
         act_data_d = shd_data_q;
         act_en_d   = shd_en_q;
         act_dp_d   = shd_dp_q;
         pending_d  = 1'b0;
      end
      if (load) begin
         shd_data_d = digit_data;
         shd_en_d   = digit_en;
         shd_dp_d   = dp;
         pending_d  = 1'b1;
      end

      frame_tick_d = (cnt_d == CNT_W'(DIGIT_CYCLES - 1)) && (idx_d == IDX_W'(NUM_DIGITS - 1));
   end

   assign dec_nib = act_data_d[{idx_d, 2'b00} +: 4];

   seg7_hex_decode u_dec (
      .nibble (dec_nib),
      .seg    (dec_seg)
   );

`ifdef SEG_PWM_EN
   localparam int SLICE = (DIGIT_CYCLES - BLANK_CYCLES) / 8;

   logic [2:0]       bright_q, bright_d;
   logic [CNT_W-1:0] drive_pos;

   always_comb begin
      bright_d  = (state_q == BLANK && state_d == DRIVE) ? brightness : bright_q;
      drive_pos = cnt_d - CNT_W'(BLANK_CYCLES);
      pwm_on    = (drive_pos / CNT_W'(SLICE)) <= CNT_W'(bright_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) bright_q <= '0;
      else     bright_q <= bright_d;
   end
`else
   assign pwm_on = 1'b1;
`endif

   // Outputs are computed from next-state values so they switch on the same edge as the FSM.
   always_comb begin
      anode_d   = '1;
      cathode_d = SEG_OFF;
      if (state_d == DRIVE) begin
         cathode_d      = {~act_dp_d[idx_d], dec_seg};
         anode_d[idx_d] = ~(act_en_d[idx_d] & pwm_on);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         shd_data_q   <= '0;
         shd_en_q     <= '0;
         shd_dp_q     <= '0;
         act_data_q   <= '0;
         act_en_q     <= '0;
         act_dp_q     <= '0;
         pending_q    <= 1'b0;
         anode_q      <= '1;
         cathode_q    <= SEG_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shd_data_q   <= shd_data_d;
         shd_en_q     <= shd_en_d;
         shd_dp_q     <= shd_dp_d;
         act_data_q   <= act_data_d;
         act_en_q     <= act_en_d;
         act_dp_q     <= act_dp_d;
         pending_q    <= pending_d;
         anode_q      <= anode_d;
         cathode_q    <= cathode_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign anode      = anode_q;
   assign cathode    = cathode_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (8 digits, 10-cycle slots, 2-cycle blank); SEG_PWM_EN adds brightness steps.
module tb_seg7_scan_ctrl;

   localparam int ND = 8;
   localparam int DC = 10;
   localparam int BC = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            load = 1'b0;
   logic [4*ND-1:0] digit_data = '0;
   logic [ND-1:0]   digit_en = '0;
   logic [ND-1:0]   dp = '0;
`ifdef SEG_PWM_EN
   logic [2:0]      brightness = 3'd3;
`endif
   logic [7:0]      cathode;
   logic [ND-1:0]   anode;
   logic            frame_tick;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .digit_data (digit_data),
      .digit_en   (digit_en),
      .dp         (dp),
`ifdef SEG_PWM_EN
      .brightness (brightness),
`endif
      .cathode    (cathode),
      .anode      (anode),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) adv();
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] p);
      digit_data = d;
      digit_en   = en;
      dp         = p;
      load       = 1'b1;
      adv();
      load       = 1'b0;
   endtask

   initial begin
      // Reset state and first frame with all digits disabled
      repeat (3) @(posedge clk);
      #1;
      chk("rst_anode", anode, 8'hFF);
      chk("rst_cathode", cathode, 8'hFF);
      chk("rst_tick", frame_tick, 1'b0);
      release_rst();
      chk("c0_anode", anode, 8'hFF);
      chk("c0_cathode", cathode, 8'hFF);
      goto(1);
      chk("c1_cathode", cathode, 8'hFF);
      goto(2);
      chk("c2_anode_off", anode, 8'hFF);
      chk("c2_cathode_drv", cathode, 8'hC0);
      goto(78);
      chk("tick_78", frame_tick, 1'b0);
      goto(79);
      chk("tick_79", frame_tick, 1'b1);
      goto(80);
      chk("tick_80", frame_tick, 1'b0);

      // Mid-frame load stays invisible until the boundary
      goto(100);
      do_load(32'h7654_3210, 8'hFF, 8'h00);
      goto(112);
      chk("mid_anode", anode, 8'hFF);
      chk("mid_cathode", cathode, 8'hC0);
      goto(159);
      chk("tick_159", frame_tick, 1'b1);
      goto(160);
      chk("f2_blank_anode", anode, 8'hFF);
      chk("f2_blank_cathode", cathode, 8'hFF);
      goto(162);
      chk("f2_s0_anode", anode, 8'hFE);
      chk("f2_s0_cathode", cathode, 8'hC0);
      goto(172);
      chk("f2_s1_anode", anode, 8'hFD);
      chk("f2_s1_cathode", cathode, 8'hF9);
      goto(192);
      chk("f2_s3_anode", anode, 8'hF7);
      chk("f2_s3_cathode", cathode, 8'hB0);
      goto(199);
      chk("f2_s3_end_anode", anode, 8'hF7);
      goto(232);
      chk("f2_s7_anode", anode, 8'h7F);
      chk("f2_s7_cathode", cathode, 8'hF8);

      // Load A mid-frame, then load B on the boundary cycle
      goto(200);
      do_load(32'hFEDC_BA98, 8'h0F, 8'h00);
      goto(239);
      chk("tick_239", frame_tick, 1'b1);
      do_load(32'h0123_4567, 8'hFF, 8'h01);
      goto(242);
      chk("f3_s0_anode", anode, 8'hFE);
      chk("f3_s0_cathode", cathode, 8'h80);
      goto(272);
      chk("f3_s3_anode", anode, 8'hF7);
      chk("f3_s3_cathode", cathode, 8'h83);
      goto(282);
      chk("f3_s4_cathode", cathode, 8'hC6);
      for (int i = 280; i < 320; i++) begin
         goto(i);
         chk("f3_hi_anode_off", anode, 8'hFF);
         if (i == 312) chk("f3_s7_cathode", cathode, 8'h8E);
         if (i == 318) chk("tick_318", frame_tick, 1'b0);
      end
      goto(319);
      chk("tick_319", frame_tick, 1'b1);
      goto(320);
      chk("f4_blank_anode", anode, 8'hFF);
      chk("f4_blank_cathode", cathode, 8'hFF);
      goto(322);
      chk("f4_s0_anode", anode, 8'hFE);
      chk("f4_s0_cathode_dp", cathode, 8'h78);
      goto(332);
      chk("f4_s1_anode", anode, 8'hFD);
      chk("f4_s1_cathode", cathode, 8'h82);

      // Asynchronous reset during DRIVE of slot 5
      goto(374);
      chk("s5_anode_pre", anode, 8'hDF);
      rst = 1'b1;
      #1;
      chk("arst_anode", anode, 8'hFF);
      chk("arst_cathode", cathode, 8'hFF);
      chk("arst_tick", frame_tick, 1'b0);
      release_rst();
      chk("r_c0_anode", anode, 8'hFF);
      chk("r_c0_cathode", cathode, 8'hFF);
      goto(2);
      chk("r_c2_anode", anode, 8'hFF);
      chk("r_c2_cathode", cathode, 8'hC0);
      goto(5);
      do_load(32'h0000_0000, 8'hFF, 8'h00);
      goto(79);
      chk("r_tick_79", frame_tick, 1'b1);

      // Duty within the DRIVE phase (full, or in eighths with SEG_PWM_EN)
      for (int i = 82; i < 90; i++) begin
         goto(i);
`ifdef SEG_PWM_EN
         chk("duty_b3_s0", anode, (i < 86) ? 8'hFE : 8'hFF);
`else
         chk("duty_full_s0", anode, 8'hFE);
`endif
      end
      goto(90);
`ifdef SEG_PWM_EN
      brightness = 3'd7;
`endif
      chk("s1_blank_anode", anode, 8'hFF);
      for (int i = 92; i < 100; i++) begin
         goto(i);
         chk("duty_s1", anode, 8'hFD);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, observed cycle %0d required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
